// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side adapter for a fifo_queue deq port.
// Pops words from a FIFO with a registered read and presents them on a
// valid/ready stream. A 2-entry skid buffer plus a credit check hides the
// one-cycle read latency, so one word per clock is sustained.
// Optional feature macro: READER_FLUSH_EN (adds flush/flush_busy and FLUSH state).

module fifo_stream_reader #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic             fifo_deq,
   input  logic [WIDTH-1:0] fifo_deq_data,
   input  logic             fifo_empty,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [CNT_W-1:0] beat_count
`ifdef READER_FLUSH_EN
  ,input  logic             flush,
   output logic             flush_busy
`endif
);

`ifdef READER_FLUSH_EN
   typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;
`else
   typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic [1:0]       buf_cnt;
   logic             pending;
   logic             pop;
   logic             capture;
   logic             flush_start;
   logic [2:0]       credit;

   assign m_valid = (buf_cnt != 2'd0);
   assign m_data  = head;
   assign pop     = m_valid && m_ready;
   assign capture = pending && (state == RUN);

`ifdef READER_FLUSH_EN
   assign flush_busy = (state == FLUSH);
`endif

   // Next-state and pop-issue logic; pops are only issued when the words
   // already buffered or in flight leave room after this cycle's transfer.
   always_comb begin
      state_next  = state;
      fifo_deq    = 1'b0;
      flush_start = 1'b0;
      credit      = {1'b0, buf_cnt} + {2'b00, pending} - {2'b00, pop};
      if (!reset) begin
         case (state)
            RUN: begin
               fifo_deq = !fifo_empty && (credit < 3'd2);
`ifdef READER_FLUSH_EN
               if (flush) begin
                  flush_start = 1'b1;
                  state_next  = FLUSH;
               end
`endif
            end
`ifdef READER_FLUSH_EN
            FLUSH: begin
               fifo_deq = !fifo_empty;
               if (fifo_empty && !pending && !flush) begin
                  state_next = RUN;
               end
            end
`endif
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // In-flight flag and accepted-beat counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= 1'b0;
         beat_count <= '0;
      end else begin
         pending <= fifo_deq;
         if (pop) begin
            beat_count <= beat_count + CNT_ONE;
         end
      end
   end

   // Skid buffer: head is always the output word; a capture coinciding with
   // a pop lands in the slot the pop frees, which keeps arrival order.
   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         buf_cnt <= 2'd0;
      end else if (flush_start || (state != RUN)) begin
         buf_cnt <= 2'd0;
      end else begin
         case ({capture, pop})
            2'b01: begin
               head    <= tail;
               buf_cnt <= buf_cnt - 2'd1;
            end
            2'b10: begin
               if (buf_cnt == 2'd0) begin
                  head <= fifo_deq_data;
               end else begin
                  tail <= fifo_deq_data;
               end
               buf_cnt <= buf_cnt + 2'd1;
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  head <= fifo_deq_data;
               end else begin
                  head <= tail;
                  tail <= fifo_deq_data;
               end
            end
            default: begin
               buf_cnt <= buf_cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. Models a FIFO with registered read,
// pushes expected words to a scoreboard when they enter the FIFO and
// compares them as the DUT completes output transfers.
// Optional feature macro: READER_FLUSH_EN (flush scenario compiled in).

module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fifo_deq;
   logic [15:0] fifo_deq_data = 16'h0;
   logic        fifo_empty = 1'b1;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [15:0] m_data;
   logic [15:0] beat_count;
`ifdef READER_FLUSH_EN
   logic        flush = 1'b0;
   logic        flush_busy;
`endif

   int          checks = 0;
   int          failures = 0;
   logic [15:0] fifo_q[$];
   logic [15:0] exp_q[$];
   int          cyc = 0;
   int          deq_total = 0;
   int          beats_total = 0;
   int          deq_pulses = 0;
   int          deq_while_empty = 0;
   int          max_out = 0;
   int          first_deq_cyc = -1;
   int          first_valid_cyc = -1;
   int          first_beat_cyc = -1;
   int          last_beat_cyc = -1;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = 16'h0;

   fifo_stream_reader #(.WIDTH(16), .CNT_W(16)) dut (
      .clk(clk),
      .reset(reset),
      .fifo_deq(fifo_deq),
      .fifo_deq_data(fifo_deq_data),
      .fifo_empty(fifo_empty),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data),
      .beat_count(beat_count)
`ifdef READER_FLUSH_EN
     ,.flush(flush),
      .flush_busy(flush_busy)
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pushWord(input logic [15:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   // One clock cycle: drive m_ready, sample and score at the falling edge,
   // then update the FIFO model just after the rising edge.
   task automatic applyStimulus(input logic ready);
      logic deq_s;
      logic stall_now;
      m_ready = ready;
      cyc++;
      @(negedge clk);
      deq_s = fifo_deq;
      if (!reset && ((deq_total - beats_total) > max_out)) max_out = deq_total - beats_total;
      if (fifo_deq) begin
         deq_total++;
         deq_pulses++;
         if (first_deq_cyc < 0) first_deq_cyc = cyc;
         if (fifo_empty) deq_while_empty++;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) checkOutput("stall_hold", {15'b0, m_valid, m_data}, {15'b0, 1'b1, prev_data});
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("scoreboard_underrun", exp_q.size(), 32'd1);
         end else begin
            checkOutput("m_data", {16'b0, m_data}, {16'b0, exp_q.pop_front()});
         end
         beats_total++;
         if (first_beat_cyc < 0) first_beat_cyc = cyc;
         last_beat_cyc = cyc;
      end
      stall_now = m_valid && !m_ready && !reset;
`ifdef READER_FLUSH_EN
      stall_now = stall_now && !flush;
`endif
      prev_stall = stall_now;
      prev_data  = m_data;
      @(posedge clk);
      #1;
      if (deq_s && fifo_q.size() > 0) fifo_deq_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic startTest();
      first_deq_cyc   = -1;
      first_valid_cyc = -1;
      first_beat_cyc  = -1;
      last_beat_cyc   = -1;
      deq_pulses      = 0;
      deq_while_empty = 0;
      max_out         = 0;
   endtask

   // One-cycle reset; words already pulled out of the FIFO are lost.
   task automatic doReset();
      int lost;
      reset = 1'b1;
      applyStimulus(1'b0);
      lost = deq_total - beats_total;
      for (int i = 0; i < lost; i++) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      deq_total   = 0;
      beats_total = 0;
      prev_stall  = 1'b0;
      reset = 1'b0;
   endtask

   // Run until the scoreboard is empty; mode 0 keeps m_ready high,
   // mode 1 uses the 1,0,0 repeating pattern.
   task automatic drain(input int mode, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         applyStimulus((mode == 0) ? 1'b1 : ((n % 3) == 0));
         n++;
      end
      checkOutput("drain_done", exp_q.size(), 32'd0);
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      checkOutput("reset_m_valid", {31'b0, m_valid}, 32'd0);
      checkOutput("reset_m_data", {16'b0, m_data}, 32'd0);
      checkOutput("reset_beat_count", {16'b0, beat_count}, 32'd0);
      checkOutput("reset_fifo_deq", {31'b0, fifo_deq}, 32'd0);
      reset = 1'b0;

      // Two words, latency and ordering
      startTest();
      pushWord(16'hAAAA);
      pushWord(16'hBBBB);
      drain(0, 20);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1);
      checkOutput("t1_latency", first_valid_cyc - first_deq_cyc, 32'd2);
      checkOutput("t1_consecutive", last_beat_cyc - first_beat_cyc, 32'd1);
      checkOutput("t1_beat_count", {16'b0, beat_count}, 32'd2);
      checkOutput("t1_deq_while_empty", deq_while_empty, 32'd0);

      // 32 words back to back
      doReset();
      startTest();
      for (int i = 0; i < 32; i++) pushWord(16'(i));
      drain(0, 100);
      checkOutput("t2_latency", first_valid_cyc - first_deq_cyc, 32'd2);
      checkOutput("t2_no_bubble", last_beat_cyc - first_beat_cyc, 32'd31);
      checkOutput("t2_beat_count", {16'b0, beat_count}, 32'd32);

      // 32 words with toggling m_ready
      doReset();
      startTest();
      for (int i = 0; i < 32; i++) pushWord(16'(i));
      drain(1, 300);
      checkOutput("t3_outstanding_le2", {31'b0, (max_out <= 2)}, 32'd1);
      checkOutput("t3_beat_count", {16'b0, beat_count}, 32'd32);
      checkOutput("t3_deq_while_empty", deq_while_empty, 32'd0);

      // Backpressure: 5 words, m_ready low for 10 cycles
      doReset();
      startTest();
      for (int i = 0; i < 5; i++) pushWord(16'h0100 + 16'(i));
      for (int i = 0; i < 10; i++) applyStimulus(1'b0);
      checkOutput("t4_deq_pulses", deq_pulses, 32'd2);
      checkOutput("t4_fifo_left", fifo_q.size(), 32'd3);
      checkOutput("t4_m_valid", {31'b0, m_valid}, 32'd1);
      drain(0, 50);
      checkOutput("t4_beat_count", {16'b0, beat_count}, 32'd5);

      // Reset while two words are buffered
      doReset();
      startTest();
      for (int i = 0; i < 6; i++) pushWord(16'h0200 + 16'(i));
      for (int i = 0; i < 4; i++) applyStimulus(1'b0);
      checkOutput("t5_fifo_left", fifo_q.size(), 32'd4);
      doReset();
      checkOutput("t5_m_valid", {31'b0, m_valid}, 32'd0);
      checkOutput("t5_beat_count", {16'b0, beat_count}, 32'd0);
      checkOutput("t5_exp_left", exp_q.size(), 32'd4);
      drain(0, 50);
      checkOutput("t5_beat_count_after", {16'b0, beat_count}, 32'd4);

`ifdef READER_FLUSH_EN
      // Flush discards everything queued, then normal operation resumes
      doReset();
      startTest();
      for (int i = 0; i < 8; i++) pushWord(16'h0300 + 16'(i));
      for (int i = 0; i < 4; i++) applyStimulus(1'b0);
      flush = 1'b1;
      applyStimulus(1'b0);
      flush = 1'b0;
      exp_q.delete();
      checkOutput("t6_flush_busy", {31'b0, flush_busy}, 32'd1);
      checkOutput("t6_m_valid", {31'b0, m_valid}, 32'd0);
      begin
         int n;
         n = 0;
         while (flush_busy && n < 40) begin
            applyStimulus(1'b1);
            checkOutput("t6_m_valid_low", {31'b0, m_valid}, 32'd0);
            n++;
         end
      end
      checkOutput("t6_flush_done", {31'b0, flush_busy}, 32'd0);
      checkOutput("t6_fifo_empty", fifo_q.size(), 32'd0);
      checkOutput("t6_beat_count", {16'b0, beat_count}, 32'd0);
      deq_total = beats_total;
      pushWord(16'h1234);
      drain(0, 20);
      checkOutput("t6_beat_count_after", {16'b0, beat_count}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side adapter for the fifo_queue deq port. It pops words from the FIFO and presents them on a valid/ready output stream. The FIFO has a registered read: data appears one cycle after deq is sampled. To hide that latency, the block keeps a 2-entry skid buffer and a credit check, so it sustains one word per clock. It sits between any fifo_queue instance and a downstream consumer.

Parameters:
WIDTH, 16, data word width; must match the fifo_queue WIDTH.
CNT_W, 16, width of the accepted-beat counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
fifo_deq  output  1  pop request to the FIFO deq port
fifo_deq_data  input  WIDTH  FIFO read data; valid the cycle after fifo_deq is sampled
fifo_empty  input  1  FIFO empty flag
m_valid  output  1  output word available
m_ready  input  1  consumer accepts the word
m_data  output  WIDTH  output word
beat_count  output  CNT_W  number of accepted output transfers, wraps modulo 2^CNT_W
flush  input  1  (READER_FLUSH_EN only) start discard of all queued data
flush_busy  output  1  (READER_FLUSH_EN only) high while in FLUSH

Behaviour:
- Single clock. Reset is synchronous and active-high on reset; all state updates on the rising edge of clk.
- Reset values:
  - fifo_deq=0, m_valid=0, m_data=0, beat_count=0.
  - Buffer count=0, pending=0, state=RUN, flush_busy=0.
- Reset mid-operation: buffered words and any in-flight read are discarded. The FIFO contents are not touched by this block.
- Internal state:
  - buf[0..1]: head/tail registers.
  - buf_cnt: 0..2.
  - pending: a deq was issued last cycle, so data arrives this cycle.
- Issue rule, combinational: fifo_deq = !reset && state==RUN && !fifo_empty && (buf_cnt + pending - pop) < 2, where pop = m_valid && m_ready.
- Capture: when pending=1, fifo_deq_data is written to the next free buffer slot. If the head is popped in the same cycle, the write goes to the slot that becomes free. Order is preserved.
- Output:
  - m_valid = (buf_cnt != 0).
  - m_data = buf head, registered.
  - m_data and m_valid stay stable while m_valid && !m_ready.
- Latency: FIFO word present with fifo_empty low at cycle N gives fifo_deq at N, capture at N+1, m_valid at N+2.
- Throughput: with m_ready held high and the FIFO non-empty, fifo_deq and m_valid/m_ready transfers occur every cycle.
- Backpressure: with m_ready low, at most 2 words are held (buf_cnt + pending ≤ 2), and fifo_deq deasserts.
- Empty: fifo_deq is never asserted while fifo_empty=1.
- Simultaneous capture and pop with buf_cnt=1: buf_cnt stays 1, and the new word becomes the head on the next cycle.
- beat_count: increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
- FSM states: RUN (normal operation) and FLUSH (present only with the feature enabled).

Optional Feature:
Macro: READER_FLUSH_EN.
- Defined:
  - flush and flush_busy ports exist.
  - flush=1 in RUN: on the next edge, buf_cnt=0, m_valid=0, and any pending arrival is discarded; state goes to FLUSH.
  - In FLUSH:
    - fifo_deq = !fifo_empty every cycle; the credit check does not apply.
    - Returned data is dropped, and m_valid stays 0.
    - beat_count is not changed.
  - FLUSH returns to RUN when fifo_empty && !pending && !flush.
  - flush asserted while already in FLUSH keeps the state in FLUSH.
  - flush_busy = (state==FLUSH).
- Undefined: no flush or flush_busy ports, and no FLUSH state.

Test Plan:
- Reset, then push 16'hAAAA and 16'hBBBB, with m_ready=1 → m_valid rises 2 cycles after the first deq; the outputs are AAAA then BBBB on consecutive cycles; beat_count=2; fifo_deq never asserts while fifo_empty=1.
- Fill the FIFO with 0..31 (DEPTH 32), m_ready=1 → 32 back-to-back transfers of 0..31 with no bubble after the first; beat_count=32.
- Fill the FIFO with 0..31 and toggle m_ready 1,0,0,1,... → no loss or duplication; buf_cnt+pending never exceeds 2; m_data stays stable while stalled.
- FIFO holds 5 words, m_ready=0 for 10 cycles → exactly 2 deq pulses; FIFO keeps 3 words; releasing m_ready delivers all 5 in order.
- Assert reset for 1 cycle while 2 words are buffered → m_valid=0 and beat_count=0 the next cycle; the remaining FIFO words are delivered afterwards in order.
- READER_FLUSH_EN: FIFO holds 8 words, 2 buffered; pulse flush → flush_busy=1; the FIFO drains to empty with m_valid=0; flush_busy falls; the next pushed word 16'h1234 is output normally.
